// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single fixed-latency memory.
// Define MEM_ARBITER_RR_EN for round-robin grant; default is fixed data priority.
module mem_arbiter #(
   parameter int ADDR_WIDTH  = 16,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [31:0]           i_rdata,
   output logic                  i_ack,
   input  logic                  d_req,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [3:0]            d_wmask,
   input  logic [31:0]           d_wdata,
   output logic [31:0]           d_rdata,
   output logic                  d_ack,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_wmask,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);

   state_t     state_r;
   state_t     state_nxt_s;
   logic       owner_d_r;
   logic       write_r;
   logic [2:0] wait_cnt_r;
   logic       grant_s;
   logic       grant_d_s;

`ifdef MEM_ARBITER_RR_EN
   logic       last_grant_d_r;
`endif

   function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
      word_align = a & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
   endfunction

   // Next-state and grant decision
   always_comb begin
      grant_s     = 1'b0;
      grant_d_s   = 1'b0;
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (i_req || d_req) begin
               grant_s = 1'b1;
`ifdef MEM_ARBITER_RR_EN
               if (i_req && d_req) begin
                  grant_d_s = ~last_grant_d_r;
               end else begin
                  grant_d_s = d_req;
               end
`else
               grant_d_s = d_req;
`endif
               state_nxt_s = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE:   state_nxt_s = WAIT;
         WAIT: begin
            if (wait_cnt_r == LAT_LAST) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register, latched transaction and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         owner_d_r  <= 1'b0;
         write_r    <= 1'b0;
         wait_cnt_r <= 3'd0;
         busy       <= 1'b0;
         mem_en     <= 1'b0;
         mem_wmask  <= 4'b0000;
         mem_addr   <= '0;
         mem_wdata  <= 32'h0000_0000;
         i_ack      <= 1'b0;
         d_ack      <= 1'b0;
         i_rdata    <= 32'h0000_0000;
         d_rdata    <= 32'h0000_0000;
`ifdef MEM_ARBITER_RR_EN
         last_grant_d_r <= 1'b0;
`endif
      end else begin
         state_r   <= state_nxt_s;
         busy      <= (state_nxt_s != IDLE);
         mem_en    <= (state_nxt_s == ISSUE);
         mem_wmask <= (grant_s && grant_d_s) ? d_wmask : 4'b0000;
         i_ack     <= (state_nxt_s == RESP) && !owner_d_r;
         d_ack     <= (state_nxt_s == RESP) && owner_d_r;
         if (grant_s) begin
            owner_d_r <= grant_d_s;
            write_r   <= grant_d_s && (d_wmask != 4'b0000);
            mem_addr  <= word_align(grant_d_s ? d_addr : i_addr);
            mem_wdata <= grant_d_s ? d_wdata : 32'h0000_0000;
`ifdef MEM_ARBITER_RR_EN
            last_grant_d_r <= grant_d_s;
`endif
         end
         if (state_r == ISSUE) begin
            wait_cnt_r <= 3'd0;
         end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + 3'd1;
         end
         // Read data is captured on the last WAIT cycle, visible with the ack
         if (state_nxt_s == RESP) begin
            if (!owner_d_r) begin
               i_rdata <= mem_rdata;
            end else if (!write_r) begin
               d_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a latency-1 and a latency-3 instance
// share stimulus; each has its own fixed-latency memory model.
module tb_mem_arbiter;

   localparam int AW = 16;
`ifdef MEM_ARBITER_RR_EN
   localparam bit RR_ON = 1'b1;
`else
   localparam bit RR_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req, d_req;
   logic [AW-1:0] i_addr, d_addr;
   logic [3:0]    d_wmask;
   logic [31:0]   d_wdata;
   logic [31:0]   mem_word;
   logic [31:0]   mem_rdata1, mem_rdata3;

   logic [31:0]   i_rdata1, d_rdata1, mem_wdata1;
   logic          i_ack1, d_ack1, mem_en1, busy1;
   logic [AW-1:0] mem_addr1;
   logic [3:0]    mem_wmask1;

   logic [31:0]   i_rdata3, d_rdata3, mem_wdata3;
   logic          i_ack3, d_ack3, mem_en3, busy3;
   logic [AW-1:0] mem_addr3;
   logic [3:0]    mem_wmask3;

   logic [7:0]    hist1 = 8'h00;
   logic [7:0]    hist3 = 8'h00;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_WIDTH(AW), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata1), .i_ack(i_ack1),
      .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
      .d_rdata(d_rdata1), .d_ack(d_ack1),
      .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_wmask(mem_wmask1),
      .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
   );

   mem_arbiter #(.ADDR_WIDTH(AW), .MEM_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata3), .i_ack(i_ack3),
      .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
      .d_rdata(d_rdata3), .d_ack(d_ack3),
      .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_wmask(mem_wmask3),
      .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
   );

   // Memory models: data valid only in cycle mem_en+LATENCY, garbage otherwise
   always @(posedge clk) begin
      hist1 <= {hist1[6:0], mem_en1};
      hist3 <= {hist3[6:0], mem_en3};
   end
   assign mem_rdata1 = hist1[0] ? mem_word : 32'hDEAD_BEEF;
   assign mem_rdata3 = hist3[2] ? mem_word : 32'hDEAD_BEEF;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      i_req   = 1'b0;
      d_req   = 1'b0;
      i_addr  = 16'h0000;
      d_addr  = 16'h0000;
      d_wmask = 4'b0000;
      d_wdata = 32'h0000_0000;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int en_cnt;
      int ack_cnt;
      int ack_at;
      logic exp_d;
      mem_word = 32'h0000_0000;
      reset = 1'b1;
      i_req = 1'b0; d_req = 1'b0;
      i_addr = 16'h0000; d_addr = 16'h0000;
      d_wmask = 4'b0000; d_wdata = 32'h0000_0000;
      tick();
      tick();
      check_eq("rst_busy",    {31'd0, busy1},  32'd0);
      check_eq("rst_mem_en",  {31'd0, mem_en1}, 32'd0);
      check_eq("rst_wmask",   {28'd0, mem_wmask1}, 32'd0);
      check_eq("rst_acks",    {30'd0, i_ack1, d_ack1}, 32'd0);
      check_eq("rst_addr",    {16'd0, mem_addr1}, 32'd0);
      check_eq("rst_wdata",   mem_wdata1, 32'd0);
      check_eq("rst_i_rdata", i_rdata1, 32'd0);
      check_eq("rst_d_rdata", d_rdata1, 32'd0);
      check_eq("rst_busy3",   {31'd0, busy3}, 32'd0);

      // Fetch, latency 1
      reset = 1'b0;
      i_req = 1'b1; i_addr = 16'h0006; mem_word = 32'h0000_0013;
      tick();
      check_eq("f_mem_en_c1", {31'd0, mem_en1}, 32'd1);
      check_eq("f_mem_addr",  {16'd0, mem_addr1}, 32'h0000_0004);
      check_eq("f_wmask",     {28'd0, mem_wmask1}, 32'd0);
      check_eq("f_busy",      {31'd0, busy1}, 32'd1);
      tick();
      check_eq("f_mem_en_c2", {31'd0, mem_en1}, 32'd0);
      check_eq("f_ack_c2",    {30'd0, i_ack1, d_ack1}, 32'd0);
      tick();
      check_eq("f_ack_c3",    {30'd0, i_ack1, d_ack1}, 32'b10);
      check_eq("f_i_rdata",   i_rdata1, 32'h0000_0013);
      i_req = 1'b0;
      tick();
      check_eq("f_ack_c4",    {30'd0, i_ack1, d_ack1}, 32'd0);
      check_eq("f_busy_c4",   {31'd0, busy1}, 32'd0);

      // Data read, then a masked write that must not disturb d_rdata
      do_reset();
      d_req = 1'b1; d_addr = 16'h0008; mem_word = 32'h5555_AAAA;
      repeat (3) tick();
      check_eq("dr_ack",   {30'd0, i_ack1, d_ack1}, 32'b01);
      check_eq("dr_rdata", d_rdata1, 32'h5555_AAAA);
      d_req = 1'b0;
      tick();
      d_req = 1'b1; d_addr = 16'h0010; d_wmask = 4'b1100; d_wdata = 32'hABCD_0000;
      mem_word = 32'h9999_9999;
      tick();
      check_eq("w_mem_en",  {31'd0, mem_en1}, 32'd1);
      check_eq("w_wmask",   {28'd0, mem_wmask1}, 32'h0000_000C);
      check_eq("w_addr",    {16'd0, mem_addr1}, 32'h0000_0010);
      check_eq("w_wdata",   mem_wdata1, 32'hABCD_0000);
      tick();
      check_eq("w_wmask_c2", {28'd0, mem_wmask1}, 32'd0);
      check_eq("w_mem_en_c2", {31'd0, mem_en1}, 32'd0);
      tick();
      check_eq("w_ack",     {30'd0, i_ack1, d_ack1}, 32'b01);
      check_eq("w_d_rdata", d_rdata1, 32'h5555_AAAA);
      d_req = 1'b0; d_wmask = 4'b0000;
      tick();
      check_eq("w_ack_c4",  {30'd0, i_ack1, d_ack1}, 32'd0);

      // Contention: both ports held for four transactions, then data drops out
      do_reset();
      i_req = 1'b1; i_addr = 16'h0100;
      d_req = 1'b1; d_addr = 16'h0200;
      mem_word = 32'h0C0F_FEE0;
      for (int s = 0; s < 4; s++) begin
         repeat (3) tick();
         exp_d = RR_ON ? ((s % 2) == 0) : 1'b1;
         check_eq($sformatf("arb_ack_s%0d", s), {30'd0, i_ack1, d_ack1}, {30'd0, ~exp_d, exp_d});
         check_eq($sformatf("arb_addr_s%0d", s), {16'd0, mem_addr1},
                  exp_d ? 32'h0000_0200 : 32'h0000_0100);
         tick();
      end
      d_req = 1'b0;
      repeat (3) tick();
      check_eq("arb_ack_last", {30'd0, i_ack1, d_ack1}, 32'b10);
      check_eq("arb_i_rdata",  i_rdata1, 32'h0C0F_FEE0);
      i_req = 1'b0;
      tick();

      // Request dropped right after grant still completes exactly once
      do_reset();
      d_req = 1'b1; d_addr = 16'h0030; mem_word = 32'h7777_0001;
      tick();
      d_req = 1'b0; d_addr = 16'hFFFC;
      check_eq("drop_mem_en", {31'd0, mem_en1}, 32'd1);
      check_eq("drop_addr",   {16'd0, mem_addr1}, 32'h0000_0030);
      en_cnt = 0; ack_cnt = 0; ack_at = 0;
      for (int k = 2; k <= 8; k++) begin
         tick();
         if (mem_en1) en_cnt++;
         if (d_ack1) begin
            ack_cnt++;
            ack_at = k;
         end
      end
      check_eq("drop_extra_en", en_cnt, 0);
      check_eq("drop_ack_cnt",  ack_cnt, 1);
      check_eq("drop_ack_at",   ack_at, 3);
      check_eq("drop_rdata",    d_rdata1, 32'h7777_0001);

      // Latency 3: reset during WAIT aborts silently, next request is normal
      do_reset();
      d_req = 1'b1; d_addr = 16'h0020; mem_word = 32'h0000_1111;
      tick();
      check_eq("l3_mem_en", {31'd0, mem_en3}, 32'd1);
      tick();
      tick();
      check_eq("l3_busy_wait", {31'd0, busy3}, 32'd1);
      reset = 1'b1; d_req = 1'b0;
      tick();
      check_eq("l3_rst_busy",  {31'd0, busy3}, 32'd0);
      check_eq("l3_rst_acks",  {30'd0, i_ack3, d_ack3}, 32'd0);
      check_eq("l3_rst_rdata", d_rdata3, 32'd0);
      reset = 1'b0;
      ack_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (i_ack3 || d_ack3) ack_cnt++;
      end
      check_eq("l3_no_ack", ack_cnt, 0);
      i_req = 1'b1; i_addr = 16'h0044; mem_word = 32'h2468_ACE0;
      tick();
      check_eq("l3_re_en",   {31'd0, mem_en3}, 32'd1);
      check_eq("l3_re_addr", {16'd0, mem_addr3}, 32'h0000_0044);
      ack_cnt = 0; ack_at = 0;
      for (int k = 2; k <= 8; k++) begin
         tick();
         if (i_ack3) begin
            ack_cnt++;
            ack_at = k;
            i_req = 1'b0;
         end
      end
      check_eq("l3_ack_cnt", ack_cnt, 1);
      check_eq("l3_ack_at",  ack_at, 5);
      check_eq("l3_i_rdata", i_rdata3, 32'h2468_ACE0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
